// File: rtl/ctrl_core_ext_if.sv
// Handshake bundle between the bin-solve controller and its host / step engines.
// The controller uses the master view; the host and step engines use the slave view.
interface ctrl_core_ext_if #(
  parameter int WIDTH_LVL    = 16,
  parameter int WIDTH_BIN_ID = 10,
  parameter int WIDTH_CNT    = 16
);
  logic                    start_core_i;
  logic                    abort_i;
  logic [WIDTH_CNT-1:0]    conflict_limit_i;
  logic [WIDTH_LVL-1:0]    cur_bin_num_i;
  logic [WIDTH_BIN_ID-1:0] bkt_bin_num_i;
  logic                    apply_imply_o;
  logic                    done_imply_i;
  logic                    conflict_i;
  logic                    all_c_is_sat_i;
  logic                    start_decision_o;
  logic                    done_decision_i;
  logic                    apply_analyze_o;
  logic                    done_analyze_i;
  logic                    apply_bkt_cur_bin_o;
  logic                    done_bkt_cur_bin_i;
  logic                    done_core_o;
  logic                    sat_o;
  logic                    unsat_o;
  logic                    abort_o;
  logic                    wdog_err_o;
  logic [WIDTH_CNT-1:0]    conflict_cnt_o;
  logic [WIDTH_CNT-1:0]    decision_cnt_o;

  modport master (
    input  start_core_i, abort_i, conflict_limit_i, cur_bin_num_i, bkt_bin_num_i,
           done_imply_i, conflict_i, all_c_is_sat_i, done_decision_i,
           done_analyze_i, done_bkt_cur_bin_i,
    output apply_imply_o, start_decision_o, apply_analyze_o, apply_bkt_cur_bin_o,
           done_core_o, sat_o, unsat_o, abort_o, wdog_err_o,
           conflict_cnt_o, decision_cnt_o
  );

  modport slave (
    output start_core_i, abort_i, conflict_limit_i, cur_bin_num_i, bkt_bin_num_i,
           done_imply_i, conflict_i, all_c_is_sat_i, done_decision_i,
           done_analyze_i, done_bkt_cur_bin_i,
    input  apply_imply_o, start_decision_o, apply_analyze_o, apply_bkt_cur_bin_o,
           done_core_o, sat_o, unsat_o, abort_o, wdog_err_o,
           conflict_cnt_o, decision_cnt_o
  );
endinterface

// File: rtl/ctrl_core_ext.sv
// Per-bin solve sequencer: imply / decide / analyze / backtrack with conflict
// budget, per-step watchdog, external abort and saturating statistics.
module ctrl_core_ext #(
  parameter int WIDTH_LVL    = 16,
  parameter int WIDTH_BIN_ID = 10,
  parameter int WIDTH_CNT    = 16,
  parameter int WIDTH_WDOG   = 12,
  parameter bit WDOG_EN      = 1'b1
) (
  input logic             clk,
  input logic             rst,
  ctrl_core_ext_if.master bus
);
  typedef enum logic [2:0] {IDLE, IMPLY, DECIDE, ANALYZE, BKT, DONE} state_t;

  localparam int WIDTH_CMP = (WIDTH_LVL > WIDTH_BIN_ID) ? WIDTH_LVL : WIDTH_BIN_ID;
  localparam logic [WIDTH_CNT-1:0] CNT_MAX = '1;
  localparam logic [WIDTH_CNT-1:0] CNT_ONE = {{(WIDTH_CNT-1){1'b0}}, 1'b1};

  state_t               state_reg;
  logic [WIDTH_CNT-1:0] conflict_cnt_reg, decision_cnt_reg, limit_reg;
  logic [WIDTH_CNT-1:0] conflict_next, decision_next;
  logic                 apply_imply_reg, start_decision_reg, apply_analyze_reg, apply_bkt_reg;
  logic                 done_core_reg, sat_reg, unsat_reg, abort_reg, wdog_err_reg;
  logic                 waiting, step_done, wdog_hit, bin_match;

  assign waiting = (state_reg == IMPLY) || (state_reg == DECIDE) ||
                   (state_reg == ANALYZE) || (state_reg == BKT);

  // Only the done input matching the current wait state counts.
  always_comb begin
    step_done = 1'b0;
    case (state_reg)
      IMPLY:   step_done = bus.done_imply_i;
      DECIDE:  step_done = bus.done_decision_i;
      ANALYZE: step_done = bus.done_analyze_i;
      BKT:     step_done = bus.done_bkt_cur_bin_i;
      default: step_done = 1'b0;
    endcase
  end

  assign conflict_next = (conflict_cnt_reg == CNT_MAX) ? CNT_MAX : conflict_cnt_reg + CNT_ONE;
  assign decision_next = (decision_cnt_reg == CNT_MAX) ? CNT_MAX : decision_cnt_reg + CNT_ONE;
  assign bin_match     = (WIDTH_CMP'(bus.bkt_bin_num_i) == WIDTH_CMP'(bus.cur_bin_num_i));

  generate
    if (WDOG_EN) begin : g_wdog
      localparam int unsigned WDOG_LAST_I = (1 << WIDTH_WDOG) - 2;
      localparam logic [WIDTH_WDOG-1:0] WDOG_LAST = WDOG_LAST_I[WIDTH_WDOG-1:0];
      localparam logic [WIDTH_WDOG-1:0] WDOG_ONE  = {{(WIDTH_WDOG-1){1'b0}}, 1'b1};
      logic [WIDTH_WDOG-1:0] wdog_reg;

      // Every abort, done or timeout leaves the state, so all of them restart the count.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          wdog_reg <= '0;
        end else if (!waiting || bus.abort_i || step_done || wdog_hit) begin
          wdog_reg <= '0;
        end else begin
          wdog_reg <= wdog_reg + WDOG_ONE;
        end
      end

      // Fires on the cycle the count would reach 2^WIDTH_WDOG-1.
      assign wdog_hit = waiting && (wdog_reg == WDOG_LAST);
    end else begin : g_no_wdog
      assign wdog_hit = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg          <= IDLE;
      conflict_cnt_reg   <= '0;
      decision_cnt_reg   <= '0;
      limit_reg          <= '0;
      apply_imply_reg    <= 1'b0;
      start_decision_reg <= 1'b0;
      apply_analyze_reg  <= 1'b0;
      apply_bkt_reg      <= 1'b0;
      done_core_reg      <= 1'b0;
      sat_reg            <= 1'b0;
      unsat_reg          <= 1'b0;
      abort_reg          <= 1'b0;
      wdog_err_reg       <= 1'b0;
    end else begin
      start_decision_reg <= 1'b0;
      done_core_reg      <= 1'b0;
      if (waiting && (bus.abort_i || (wdog_hit && !step_done))) begin
        state_reg         <= DONE;
        done_core_reg     <= 1'b1;
        abort_reg         <= bus.abort_i;
        wdog_err_reg      <= !bus.abort_i;
        apply_imply_reg   <= 1'b0;
        apply_analyze_reg <= 1'b0;
        apply_bkt_reg     <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: if (bus.start_core_i) begin
            state_reg        <= IMPLY;
            apply_imply_reg  <= 1'b1;
            conflict_cnt_reg <= '0;
            decision_cnt_reg <= '0;
            limit_reg        <= bus.conflict_limit_i;
            sat_reg          <= 1'b0;
            unsat_reg        <= 1'b0;
            abort_reg        <= 1'b0;
            wdog_err_reg     <= 1'b0;
          end
          IMPLY: if (bus.done_imply_i) begin
            apply_imply_reg <= 1'b0;
            if (bus.conflict_i) begin
              conflict_cnt_reg <= conflict_next;
              if ((limit_reg != '0) && (conflict_next >= limit_reg)) begin
                state_reg     <= DONE;
                done_core_reg <= 1'b1;
                abort_reg     <= 1'b1;
              end else begin
                state_reg         <= ANALYZE;
                apply_analyze_reg <= 1'b1;
              end
            end else if (bus.all_c_is_sat_i) begin
              state_reg     <= DONE;
              done_core_reg <= 1'b1;
              sat_reg       <= 1'b1;
            end else begin
              state_reg          <= DECIDE;
              start_decision_reg <= 1'b1;
            end
          end
          DECIDE: if (bus.done_decision_i) begin
            decision_cnt_reg <= decision_next;
            state_reg        <= IMPLY;
            apply_imply_reg  <= 1'b1;
          end
          ANALYZE: if (bus.done_analyze_i) begin
            apply_analyze_reg <= 1'b0;
            if (bin_match) begin
              state_reg     <= BKT;
              apply_bkt_reg <= 1'b1;
            end else begin
              state_reg     <= DONE;
              done_core_reg <= 1'b1;
              unsat_reg     <= 1'b1;
            end
          end
          BKT: if (bus.done_bkt_cur_bin_i) begin
            apply_bkt_reg   <= 1'b0;
            state_reg       <= IMPLY;
            apply_imply_reg <= 1'b1;
          end
          DONE:    state_reg <= IDLE;
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign bus.apply_imply_o       = apply_imply_reg;
  assign bus.start_decision_o    = start_decision_reg;
  assign bus.apply_analyze_o     = apply_analyze_reg;
  assign bus.apply_bkt_cur_bin_o = apply_bkt_reg;
  assign bus.done_core_o         = done_core_reg;
  assign bus.sat_o               = sat_reg;
  assign bus.unsat_o             = unsat_reg;
  assign bus.abort_o             = abort_reg;
  assign bus.wdog_err_o          = wdog_err_reg;
  assign bus.conflict_cnt_o      = conflict_cnt_reg;
  assign bus.decision_cnt_o      = decision_cnt_reg;
endmodule
